// File: rtl/dmem_hs.sv
// Byte-addressable data RAM behind a valid/ready request/response handshake, with programmable latency,
// RISC-V load extension and range/alignment error responses. Define DMEM_MISALIGN_EN to allow misaligned accesses (+1 cycle).
module dmem_hs #(
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
  parameter int          DEPTH_BYTES = 256,
  parameter int          LATENCY     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_size,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int AW = $clog2(DEPTH_BYTES);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t      state, state_nxt;
  logic [4:0]  cnt, cnt_nxt;
  logic        lat_we;
  logic [31:0] lat_addr, lat_wdata;
  logic [2:0]  lat_size;

  logic [7:0]  mem [DEPTH_BYTES];

  logic        accept;
  logic        a_we;
  logic [31:0] a_addr, a_wdata;
  logic [2:0]  a_size;

  logic [31:0] off;
  logic [32:0] end_off;
  logic [2:0]  nbytes;
  logic [3:0]  be;
  logic        size_ok, in_range, misal, err, slow;
  logic [4:0]  lat_load;
  logic        access_fire;

  logic [AW-1:0] idx0, idx1, idx2, idx3;
  logic [7:0]    b0, b1, b2, b3;
  logic [31:0]   rd_ext;

  assign req_ready  = (state == IDLE) && !reset;
  assign resp_valid = (state == RESP);
  assign accept     = req_valid && req_ready;

  // At the accept edge the access is decoded from the live request; afterwards from the latched copy.
  assign a_we    = (state == IDLE) ? req_we    : lat_we;
  assign a_addr  = (state == IDLE) ? req_addr  : lat_addr;
  assign a_wdata = (state == IDLE) ? req_wdata : lat_wdata;
  assign a_size  = (state == IDLE) ? req_size  : lat_size;

  always_comb begin
    nbytes = 3'd4;
    be     = 4'b1111;
    case (a_size[1:0])
      2'b00:   begin nbytes = 3'd1; be = 4'b0001; end
      2'b01:   begin nbytes = 3'd2; be = 4'b0011; end
      default: begin nbytes = 3'd4; be = 4'b1111; end
    endcase
    off      = a_addr - BASE_ADDR;
    end_off  = {1'b0, off} + {30'b0, nbytes};
    size_ok  = (a_size[1:0] != 2'b11) && !(a_size[2] && a_size[1]) && !(a_we && a_size[2]);
    in_range = (a_addr >= BASE_ADDR) && (end_off <= 33'(DEPTH_BYTES));
    misal    = ((nbytes == 3'd2) && off[0]) || ((nbytes == 3'd4) && (off[1:0] != 2'b00));
`ifdef DMEM_MISALIGN_EN
    err      = !size_ok || !in_range;
    slow     = !err && misal;
`else
    err      = !size_ok || !in_range || misal;
    slow     = 1'b0;
`endif
    lat_load = 5'(LATENCY - 1) + {4'b0, slow};
  end

  assign idx0 = off[AW-1:0];
  assign idx1 = idx0 + AW'(1);
  assign idx2 = idx0 + AW'(2);
  assign idx3 = idx0 + AW'(3);
  assign b0   = mem[idx0];
  assign b1   = mem[idx1];
  assign b2   = mem[idx2];
  assign b3   = mem[idx3];

  always_comb begin
    rd_ext = 32'h0;
    case (a_size)
      3'b000:  rd_ext = {{24{b0[7]}}, b0};
      3'b001:  rd_ext = {{16{b1[7]}}, b1, b0};
      3'b010:  rd_ext = {b3, b2, b1, b0};
      3'b100:  rd_ext = {24'h0, b0};
      3'b101:  rd_ext = {16'h0, b1, b0};
      default: rd_ext = 32'h0;
    endcase
    if (err || a_we) rd_ext = 32'h0;
  end

  // With a single-cycle latency the access happens on the accept edge itself.
  assign access_fire = ((state == IDLE) && accept && (lat_load == 5'd0)) ||
                       ((state == BUSY) && (cnt == 5'd0));

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (accept) begin
          cnt_nxt   = lat_load;
          state_nxt = (lat_load == 5'd0) ? RESP : BUSY;
        end
      end
      BUSY: begin
        if (cnt == 5'd0) state_nxt = RESP;
        else             cnt_nxt   = cnt - 5'd1;
      end
      RESP: begin
        if (resp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= 5'd0;
      lat_we     <= 1'b0;
      lat_addr   <= 32'h0;
      lat_wdata  <= 32'h0;
      lat_size   <= 3'b0;
      resp_rdata <= 32'h0;
      resp_err   <= 1'b0;
      for (int i = 0; i < DEPTH_BYTES; i++) mem[i] <= 8'h00;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (accept) begin
        lat_we    <= req_we;
        lat_addr  <= req_addr;
        lat_wdata <= req_wdata;
        lat_size  <= req_size;
      end
      if (access_fire) begin
        resp_rdata <= rd_ext;
        resp_err   <= err;
        if (a_we && !err) begin
          if (be[0]) mem[idx0] <= a_wdata[7:0];
          if (be[1]) mem[idx1] <= a_wdata[15:8];
          if (be[2]) mem[idx2] <= a_wdata[23:16];
          if (be[3]) mem[idx3] <= a_wdata[31:24];
        end
      end
    end
  end

endmodule

// File: tb/tb_dmem_hs.sv
// Randomized and directed bench for dmem_hs against a byte-array reference model.
module tb_dmem_hs;
  localparam logic [31:0] BASE  = 32'h8000_0000;
  localparam int          DEPTH = 256;
  localparam int          LAT   = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0, req_ready, req_we = 1'b0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic [2:0]  req_size = '0;
  logic        resp_valid, resp_ready = 1'b0;
  logic [31:0] resp_rdata;
  logic        resp_err;

  int n_vec = 0;
  int n_bad = 0;
  logic [7:0] ref_mem [DEPTH];

  always #5 clk = ~clk;

  dmem_hs #(.BASE_ADDR(BASE), .DEPTH_BYTES(DEPTH), .LATENCY(LAT)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic ref_clear();
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = 8'h00;
  endtask

  // Reference semantics straight from the access rules: size table, offset range, alignment, extension.
  task automatic ref_access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [2:0] size, output logic [31:0] rdata,
                            output logic err, output int lat);
    int n;
    longint off;
    bit legal, inr, mis;
    logic [31:0] v;
    case (size)
      3'd0, 3'd4: n = 1;
      3'd1, 3'd5: n = 2;
      3'd2:       n = 4;
      default:    n = 0;
    endcase
    legal = (n != 0) && !(we && size >= 3'd4);
    off   = longint'({32'b0, addr}) - longint'({32'b0, BASE});
    inr   = (off >= 0) && (off + n <= DEPTH);
    mis   = ((n == 2) && (off % 2 != 0)) || ((n == 4) && (off % 4 != 0));
`ifdef DMEM_MISALIGN_EN
    err = !legal || !inr;
    lat = LAT + ((mis && !err) ? 1 : 0);
`else
    err = !legal || !inr || mis;
    lat = LAT;
`endif
    rdata = 32'h0;
    if (!err) begin
      if (we) begin
        for (int i = 0; i < n; i++) ref_mem[int'(off) + i] = wdata[8*i +: 8];
      end else begin
        v = 32'h0;
        for (int i = 0; i < n; i++) v = v | (32'(ref_mem[int'(off) + i]) << (8 * i));
        if (size == 3'd0 && v[7])  v = v | 32'hFFFF_FF00;
        if (size == 3'd1 && v[15]) v = v | 32'hFFFF_0000;
        rdata = v;
      end
    end
  endtask

  task automatic txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [2:0] size, input int hold, input bit scramble,
                     output logic [31:0] rd);
    logic [31:0] erd, rd0;
    logic        eerr, er0;
    int          elat, lat;
    bit          seen;
    ref_access(we, addr, wdata, size, erd, eerr, elat);
    rd = 32'hx;
    @(negedge clk);
    chk("req_ready_idle", req_ready, 1);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_size = size;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 0; seen = 0;
    while (lat < 40 && !seen) begin
      if (scramble) begin
        req_we = 1'($urandom); req_addr = $urandom; req_wdata = $urandom; req_size = 3'($urandom);
      end
      @(posedge clk); lat++;
      @(negedge clk);
      if (resp_valid) seen = 1;
      else chk("req_ready_busy", req_ready, 0);
    end
    if (!seen) begin
      chk("resp_timeout", 0, 1);
      return;
    end
    chk("latency", lat, elat);
    rd0 = resp_rdata; er0 = resp_err;
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); @(negedge clk);
      chk("hold_valid", resp_valid, 1);
      chk("hold_rdata", resp_rdata, rd0);
      chk("hold_err", resp_err, er0);
      chk("hold_ready", req_ready, 0);
    end
    chk("rdata", resp_rdata, erd);
    chk("err", resp_err, eerr);
    rd = resp_rdata;
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    @(negedge clk);
    chk("valid_after_hs", resp_valid, 0);
    chk("ready_after_hs", req_ready, 1);
  endtask

  logic [31:0] rd;
  logic [31:0] a;

  initial begin
    ref_clear();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("ready_in_reset", req_ready, 0);
    chk("valid_in_reset", resp_valid, 0);
    reset = 1'b0;
    @(negedge clk);
    chk("ready_after_reset", req_ready, 1);
    chk("valid_after_reset", resp_valid, 0);
    chk("rdata_after_reset", resp_rdata, 0);
    chk("err_after_reset", resp_err, 0);

    txn(0, BASE, 0, 3'b010, 0, 0, rd);               chk("lw_zero", rd, 32'h0);
    txn(1, BASE + 32'h10, 32'hDEAD_BEEF, 3'b010, 0, 1, rd);
    txn(0, BASE + 32'h10, 0, 3'b010, 0, 1, rd);      chk("lw_deadbeef", rd, 32'hDEAD_BEEF);
    txn(0, BASE + 32'h10, 0, 3'b000, 0, 1, rd);      chk("lb", rd, 32'hFFFF_FFEF);
    txn(0, BASE + 32'h10, 0, 3'b100, 0, 1, rd);      chk("lbu", rd, 32'h0000_00EF);
    txn(0, BASE + 32'h12, 0, 3'b101, 0, 1, rd);      chk("lhu", rd, 32'h0000_DEAD);
    txn(0, BASE + 32'h12, 0, 3'b001, 0, 1, rd);      chk("lh", rd, 32'hFFFF_DEAD);
    txn(1, BASE + 32'h20, 32'hAABB_CCDD, 3'b010, 0, 1, rd);
    txn(1, BASE + 32'h20, 32'h0000_1234, 3'b001, 0, 1, rd);
    txn(0, BASE + 32'h20, 0, 3'b010, 0, 1, rd);      chk("sh_merge", rd, 32'hAABB_1234);

    txn(0, BASE + 32'hFE, 0, 3'b010, 0, 1, rd);
    txn(0, 32'h7FFF_FFFC, 0, 3'b010, 0, 1, rd);
    txn(0, BASE + 32'h11, 0, 3'b010, 0, 1, rd);
    txn(1, BASE + 32'h10, 32'h0, 3'b100, 0, 1, rd);
    txn(1, BASE + 32'h10, 32'h0, 3'b011, 0, 1, rd);
    txn(1, BASE + 32'hFC, 32'h5555_5555, 3'b010, 0, 1, rd);
    txn(0, BASE + 32'hFC, 0, 3'b010, 0, 1, rd);      chk("top_word", rd, 32'h5555_5555);
    txn(0, BASE + 32'h10, 0, 3'b010, 5, 1, rd);      chk("untouched", rd, 32'hDEAD_BEEF);

    // Reset while the store is still in BUSY: it must never land or respond.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = BASE + 32'h40; req_wdata = 32'h1122_3344; req_size = 3'b010;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("valid_reset_edge", resp_valid, 0);
    @(negedge clk);
    reset = 1'b0;
    ref_clear();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("no_resp_after_reset", resp_valid, 0);
    end
    txn(0, BASE + 32'h40, 0, 3'b010, 0, 1, rd);      chk("dropped_store", rd, 32'h0);
    txn(0, BASE + 32'h10, 0, 3'b010, 0, 1, rd);      chk("mem_zeroed", rd, 32'h0);

    for (int t = 0; t < 200; t++) begin
      case ($urandom_range(0, 9))
        0:       a = $urandom;
        1:       a = BASE - 32'($urandom_range(1, 8));
        default: a = BASE + 32'($urandom_range(0, DEPTH + 3));
      endcase
      txn(1'($urandom), a, $urandom, 3'($urandom_range(0, 7)),
          int'($urandom_range(0, 3)), 1'($urandom), rd);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end
endmodule

// File: doc/dmem_hs.md
Name: dmem_hs

Overview:
- Parametrised, byte-addressable data memory for the multi-cycle processor.
- Sits between the load/store unit and local data RAM.
- Adds over the single-cycle data memory:
  - valid/ready request and response handshake with programmable access latency
  - RISC-V load sign/zero extension
  - range and alignment checking with an error response

Parameters:
- BASE_ADDR, 32'h8000_0000, first byte address decoded by the block.
- DEPTH_BYTES, 256, memory size in bytes; power of two, at least 4.
- LATENCY, 2, cycles from request accept to resp_valid; legal range 1..15.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  synchronous, active-high; clears all state and zeroes memory.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned.
- req_size  in  3  funct3 encoding: 000 byte, 001 half, 010 word, 100 byte-unsigned, 101 half-unsigned.
- resp_valid  out  1  response present.
- resp_ready  in  1  consumer accepts response.
- resp_rdata  out  32  load result, extended to 32 bits; 0 for stores and errors.
- resp_err  out  1  access rejected.

Behaviour:
- Reset values: req_ready=0 during the reset cycle, then 1; resp_valid=0, resp_rdata=0, resp_err=0; FSM in IDLE; all memory bytes 0.
- FSM states: IDLE, BUSY, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid&req_ready, latch we/addr/wdata/size and load the down-counter with LATENCY-1.
  - If LATENCY-1=0, go straight to RESP; otherwise go to BUSY.
- BUSY:
  - req_ready=0; decrement the counter each cycle.
  - The cycle the counter reads 0 is the access edge: a store commits to memory, or load data plus error are registered. Then go to RESP.
  - Net latency: resp_valid is asserted exactly LATENCY cycles after the accept edge.
- RESP:
  - resp_valid=1; resp_rdata and resp_err held stable until resp_ready.
  - On resp_ready, go to IDLE; resp_valid=0 next cycle.
  - No new request is accepted in the same cycle (one outstanding transaction).
- Offset and range:
  - off = addr - BASE_ADDR, 32-bit unsigned.
  - In range only when addr >= BASE_ADDR and off + nbytes <= DEPTH_BYTES, where nbytes is 1, 2 or 4.
- Little-endian byte order. Byte off holds wdata[7:0]; a word occupies off..off+3.
- Loads:
  - size 000 and 001 sign-extend from bit 7 / bit 15.
  - size 100 and 101 zero-extend.
  - size 010 returns the full word.
- Error conditions (resp_err=1, memory untouched, resp_rdata=0, same latency):
  - size 011, 110 or 111
  - store with size 100 or 101
  - out of range, including straddling the top byte
  - misaligned access: half at odd off, or word with off[1:0]!=0
- Input changes while in BUSY or RESP are ignored, because all request fields are latched at accept.
- Reset mid-transaction:
  - Returns to IDLE; any pending store is dropped.
  - resp_valid falls on the reset edge; memory is zeroed.
- Ignoring resp_ready: the block holds RESP indefinitely with outputs stable.

Optional Feature:
- Macro: DMEM_MISALIGN_EN.
- Defined:
  - Misaligned in-range half/word accesses are legal and not errors.
  - They cost one extra BUSY cycle, so resp_valid comes LATENCY+1 cycles after accept.
  - Bytes are still read/written at off..off+nbytes-1.
- Undefined: misaligned accesses produce resp_err=1 at normal latency.

Test Plan:
- Reset then idle: check req_ready=1 and resp_valid=0 one cycle after reset deasserts. A load word at 0x8000_0000 returns 0x0000_0000 with err=0.
- Store word 0xDEADBEEF at 0x8000_0010, then:
  - load word returns 0xDEADBEEF with resp_valid exactly 2 cycles after accept;
  - load byte at 0x8000_0010 returns 0xFFFF_FFEF;
  - load byte-unsigned returns 0x0000_00EF;
  - load half-unsigned at 0x8000_0012 returns 0x0000_DEAD.
- Store half 0x1234 at 0x8000_0020 over an existing word 0xAABBCCDD: a load word returns 0xAABB1234.
- Errors, each with err=1 and no memory change:
  - load word at 0x8000_00FE (out of range)
  - load word at 0x7FFF_FFFC (below base)
  - load word at 0x8000_0011 (misaligned, macro off)
  - store size 100
  - size 011
- Hold resp_ready=0 for 5 cycles in RESP: data stays stable and req_ready stays 0. Raising resp_ready gives IDLE the next cycle.
- Assert reset in BUSY during a store of 0x11223344 to 0x8000_0040: no response is produced, and a later load there returns 0.
